pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB).
- Inputs: decode-stage source registers, EX/MEM destination info, memory handshake and redirect requests.
- Outputs: per-stage stall, bubble and flush controls, so the decoder and fetch unit no longer carry private stall counters.
- Sits beside the decoder; drives IF, ID and the ID/EX pipeline register.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_hazard_compare.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: RV64 opcodes, NOP encoding,
// FSM state encodings and the per-stage control bundle.
package pipeline_hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // addi x0, x0, 0 -- what ID/EX is loaded with when bubble_ex is high
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_MEM_WAIT  = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_LOAD_USE  = 3'd3,
        ST_JALR_WAIT = 3'd4
    } state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic bubble_ex;
        logic flush_if;
        logic flush_id;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE      = ctrl_t'(7'b0000000);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(7'b1111000);
    localparam ctrl_t CTRL_BUBBLE    = ctrl_t'(7'b1100100);
    localparam ctrl_t CTRL_FLUSH     = ctrl_t'(7'b0000011);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard sequencer: hazard inputs from ID/EX/MEM and
// the per-stage stall/bubble/flush controls returned to IF, ID and ID/EX.
interface pipeline_hazard_ctrl_if;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       ex_wb;
    logic [4:0] mem_rd;
    logic       mem_load;
    logic       mem_req;
    logic       mem_ready;
    logic       redirect;

    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       stall_mem;
    logic       bubble_ex;
    logic       flush_if;
    logic       flush_id;
    logic       mem_timeout;
    logic [2:0] state_o;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs2,
               ex_rd, ex_load, ex_wb, mem_rd, mem_load,
               mem_req, mem_ready, redirect,
        input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
               flush_if, flush_id, mem_timeout, state_o
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs2,
               ex_rd, ex_load, ex_wb, mem_rd, mem_load,
               mem_req, mem_ready, redirect,
        output stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
               flush_if, flush_id, mem_timeout, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// Purely combinational load-use and JALR-source hazard detection; x0 never
// creates a hazard. Kept standalone so the decoder can reuse it.
module pipeline_hazard_ctrl_hazard_compare
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_load,
    input  logic       ex_wb,
    input  logic [4:0] mem_rd,
    input  logic       mem_load,
    output logic       load_use,
    output logic       jalr_haz
);

    logic rs1_hits_ex;
    logic rs2_hits_ex;
    logic rs1_hits_mem;

    assign rs1_hits_ex  = (id_rs1 == ex_rd);
    assign rs2_hits_ex  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign rs1_hits_mem = (id_rs1 == mem_rd);

    assign load_use = id_valid && ex_load && (ex_rd != 5'd0) && (rs1_hits_ex || rs2_hits_ex);

    // JALR needs its base in ID for target calculation, so even ALU results are too late
    assign jalr_haz = id_valid && (id_opcode == OPC_JALR) && (id_rs1 != 5'd0) &&
                      ((ex_wb && rs1_hits_ex) || (mem_load && rs1_hits_mem));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV64 pipeline. Controls are combinational
// from state and inputs; optional perf counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int XLEN         = 64
) (
    input  logic                   CLK,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [XLEN-1:0]        perf_stall_cycles,
    output logic [XLEN-1:0]        perf_flushes,
    output logic [XLEN-1:0]        perf_bubbles
`endif
);

    localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [1:0] FL_FULL   = 2'(FLUSH_CYCLES);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state,   state_nx;
    logic [1:0] flush_cnt, flush_nx;
    logic [7:0] wait_cnt,  wait_nx;
    logic       pending_redirect, pend_nx;
    logic       mem_timeout_q, tmo_nx;
    logic       redir_acc;
    ctrl_t      ctrl, ctrl_o;

    logic load_use;
    logic jalr_haz;
    logic mem_block;

    pipeline_hazard_ctrl_hazard_compare u_cmp (
        .id_valid    (hz.id_valid),
        .id_opcode   (hz.id_opcode),
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_uses_rs2 (hz.id_uses_rs2),
        .ex_rd       (hz.ex_rd),
        .ex_load     (hz.ex_load),
        .ex_wb       (hz.ex_wb),
        .mem_rd      (hz.mem_rd),
        .mem_load    (hz.mem_load),
        .load_use    (load_use),
        .jalr_haz    (jalr_haz)
    );

    assign mem_block = hz.mem_req && !hz.mem_ready;

    always_comb begin
        ctrl      = CTRL_NONE;
        state_nx  = state;
        flush_nx  = flush_cnt;
        wait_nx   = wait_cnt;
        pend_nx   = pending_redirect;
        tmo_nx    = mem_timeout_q;
        redir_acc = 1'b0;

        case (state)
            ST_MEM_WAIT: begin
                ctrl    = CTRL_MEM_STALL;
                pend_nx = pending_redirect || hz.redirect;
                wait_nx = wait_cnt + 8'd1;
                if (hz.mem_ready) begin
                    wait_nx = '0;
                    pend_nx = 1'b0;
                    // No flush was issued during the wait, so the deferred redirect gets the full window
                    if (pending_redirect || hz.redirect) begin
                        state_nx  = ST_FLUSH;
                        flush_nx  = FL_FULL;
                        redir_acc = 1'b1;
                    end else begin
                        state_nx = ST_RUN;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = ST_RUN;
                    wait_nx  = '0;
                    pend_nx  = 1'b0;
                end
            end

            ST_FLUSH: begin
                if (mem_block) begin
                    // Freeze everything and replay the whole flush once memory answers
                    ctrl     = CTRL_MEM_STALL;
                    state_nx = ST_MEM_WAIT;
                    wait_nx  = '0;
                    pend_nx  = 1'b1;
                    flush_nx = '0;
                end else begin
                    ctrl = CTRL_FLUSH;
                    if (hz.redirect) begin
                        flush_nx  = FL_RELOAD;
                        redir_acc = 1'b1;
                    end else begin
                        flush_nx = flush_cnt - 2'd1;
                    end
                    if (flush_nx == 2'd0) begin
                        state_nx = ST_RUN;
                    end
                end
            end

            default: begin
                // RUN, LOAD_USE and JALR_WAIT share priorities; LOAD_USE skips hazard checks since the load now forwards
                if (mem_block) begin
                    ctrl     = CTRL_MEM_STALL;
                    state_nx = ST_MEM_WAIT;
                    wait_nx  = '0;
                    pend_nx  = hz.redirect;
                end else if (hz.redirect) begin
                    ctrl      = CTRL_FLUSH;
                    flush_nx  = FL_RELOAD;
                    redir_acc = 1'b1;
                    state_nx  = (FL_RELOAD == 2'd0) ? ST_RUN : ST_FLUSH;
                end else if ((state != ST_LOAD_USE) && load_use) begin
                    ctrl     = CTRL_BUBBLE;
                    state_nx = ST_LOAD_USE;
                end else if ((state != ST_LOAD_USE) && jalr_haz) begin
                    ctrl     = CTRL_BUBBLE;
                    state_nx = ST_JALR_WAIT;
                end else begin
                    state_nx = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state            <= ST_RUN;
            flush_cnt        <= '0;
            wait_cnt         <= '0;
            pending_redirect <= 1'b0;
            mem_timeout_q    <= 1'b0;
        end else begin
            state            <= state_nx;
            flush_cnt        <= flush_nx;
            wait_cnt         <= wait_nx;
            pending_redirect <= pend_nx;
            mem_timeout_q    <= tmo_nx;
        end
    end

    assign ctrl_o = reset ? ctrl : CTRL_NONE;

    assign hz.stall_if    = ctrl_o.stall_if;
    assign hz.stall_id    = ctrl_o.stall_id;
    assign hz.stall_ex    = ctrl_o.stall_ex;
    assign hz.stall_mem   = ctrl_o.stall_mem;
    assign hz.bubble_ex   = ctrl_o.bubble_ex;
    assign hz.flush_if    = ctrl_o.flush_if;
    assign hz.flush_id    = ctrl_o.flush_id;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.state_o     = state;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_bubbles      <= '0;
        end else begin
            if (ctrl_o.stall_if)  perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (redir_acc)        perf_flushes      <= perf_flushes + 1'b1;
            if (ctrl_o.bubble_ex) perf_bubbles      <= perf_bubbles + 1'b1;
        end
    end
`else
    logic [XLEN-1:0] perf_unused;
    assign perf_unused = XLEN'(redir_acc);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle RUN-state vector table plus
// hand-written multi-cycle sequences (mem wait, flush, JALR wait, timeout, reset).
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic CLK;
    logic reset;
    int   checks;
    int   failures;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (15),
        .XLEN         (64)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .hz    (hz)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      nm;
        logic       id_valid;
        logic [6:0] opc;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic [4:0] ex_rd;
        logic       ex_load;
        logic       ex_wb;
        logic [4:0] mem_rd;
        logic       mem_load;
        logic       mem_req;
        logic       mem_ready;
        logic       redirect;
        logic [6:0] exp_ctrl;
        logic [2:0] exp_next;
    } vec_t;

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if, flush_id}
    localparam logic [6:0] C0 = 7'b0000000;
    localparam logic [6:0] CM = 7'b1111000;
    localparam logic [6:0] CB = 7'b1100100;
    localparam logic [6:0] CF = 7'b0000011;

    vec_t vecs [17];

    function automatic logic [6:0] cur_ctrl();
        return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
                hz.bubble_ex, hz.flush_if, hz.flush_id};
    endfunction

    task automatic check_cs(input string nm, input logic [6:0] ec, input logic [2:0] es);
        checks++;
        if (cur_ctrl() !== ec || hz.state_o !== es) begin
            failures++;
            $display("FAIL %s: ctrl=%b state=%0d, expected ctrl=%b state=%0d",
                     nm, cur_ctrl(), hz.state_o, ec, es);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", nm, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.id_valid = 1'b0; hz.id_opcode = OPC_OP; hz.id_rs1 = '0; hz.id_rs2 = '0;
        hz.id_uses_rs2 = 1'b0; hz.ex_rd = '0; hz.ex_load = 1'b0; hz.ex_wb = 1'b0;
        hz.mem_rd = '0; hz.mem_load = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
        hz.redirect = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        hz.id_valid = v.id_valid; hz.id_opcode = v.opc; hz.id_rs1 = v.rs1; hz.id_rs2 = v.rs2;
        hz.id_uses_rs2 = v.uses_rs2; hz.ex_rd = v.ex_rd; hz.ex_load = v.ex_load; hz.ex_wb = v.ex_wb;
        hz.mem_rd = v.mem_rd; hz.mem_load = v.mem_load; hz.mem_req = v.mem_req;
        hz.mem_ready = v.mem_ready; hz.redirect = v.redirect;
    endtask

    task automatic reset_pulse();
        clear_inputs();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic set_ld_use(input logic [4:0] r);
        hz.id_valid = 1'b1; hz.id_opcode = OPC_OP; hz.id_rs1 = r; hz.ex_load = 1'b1; hz.ex_rd = r;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //          nm        vld opc         rs1 rs2 u2 exrd ld wb mrd ml rq rdy rd  ctrl next
        vecs[0]  = '{"idle",    0, OPC_OP,     0,  0, 0,  0,  0, 0,  0, 0, 0, 0, 0, C0, 3'd0};
        vecs[1]  = '{"lu_rs1",  1, OPC_OP,     5,  2, 0,  5,  1, 1,  0, 0, 0, 0, 0, CB, 3'd3};
        vecs[2]  = '{"lu_x0",   1, OPC_OP,     0,  2, 0,  0,  1, 1,  0, 0, 0, 0, 0, C0, 3'd0};
        vecs[3]  = '{"lu_rs2",  1, OPC_OP,     1,  6, 1,  6,  1, 1,  0, 0, 0, 0, 0, CB, 3'd3};
        vecs[4]  = '{"rs2_nu",  1, OPC_OP_IMM, 1,  6, 0,  6,  1, 1,  0, 0, 0, 0, 0, C0, 3'd0};
        vecs[5]  = '{"id_inv",  0, OPC_OP,     5,  2, 0,  5,  1, 1,  0, 0, 0, 0, 0, C0, 3'd0};
        vecs[6]  = '{"alu_fwd", 1, OPC_OP,     5,  2, 0,  5,  0, 1,  0, 0, 0, 0, 0, C0, 3'd0};
        vecs[7]  = '{"jalr_ex", 1, OPC_JALR,   7,  0, 0,  7,  0, 1,  0, 0, 0, 0, 0, CB, 3'd4};
        vecs[8]  = '{"jalr_mm", 1, OPC_JALR,   7,  0, 0,  0,  0, 0,  7, 1, 0, 0, 0, CB, 3'd4};
        vecs[9]  = '{"jalr_x0", 1, OPC_JALR,   0,  0, 0,  0,  0, 1,  0, 1, 0, 0, 0, C0, 3'd0};
        vecs[10] = '{"jalr_na", 1, OPC_JALR,   7,  0, 0,  0,  0, 0,  7, 0, 0, 0, 0, C0, 3'd0};
        vecs[11] = '{"redir",   0, OPC_OP,     0,  0, 0,  0,  0, 0,  0, 0, 0, 0, 1, CF, 3'd2};
        vecs[12] = '{"red_lu",  1, OPC_OP,     5,  0, 0,  5,  1, 1,  0, 0, 0, 0, 1, CF, 3'd2};
        vecs[13] = '{"memwait", 0, OPC_OP,     0,  0, 0,  0,  0, 0,  0, 0, 1, 0, 0, CM, 3'd1};
        vecs[14] = '{"mem_rdy", 0, OPC_OP,     0,  0, 0,  0,  0, 0,  0, 0, 1, 1, 0, C0, 3'd0};
        vecs[15] = '{"mem_all", 1, OPC_OP,     5,  0, 0,  5,  1, 1,  0, 0, 1, 0, 1, CM, 3'd1};
        vecs[16] = '{"mld_fwd", 1, OPC_OP,     7,  0, 0,  0,  0, 0,  7, 1, 0, 0, 0, C0, 3'd0};

        // reset: outputs forced low even with hazard-causing inputs present
        clear_inputs();
        reset = 1'b0;
        hz.mem_req = 1'b1; hz.redirect = 1'b1; set_ld_use(5'd5);
        repeat (2) @(negedge CLK);
        #1;
        check_cs("reset_state", C0, 3'd0);
        check_bit("reset_timeout", hz.mem_timeout, 1'b0);
        @(negedge CLK);
        clear_inputs();
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge CLK);
            apply(vecs[i]);
            #1;
            check_cs({vecs[i].nm, "_out"}, vecs[i].exp_ctrl, 3'd0);
            @(posedge CLK);
            #1;
            checks++;
            if (hz.state_o !== vecs[i].exp_next) begin
                failures++;
                $display("FAIL %s_next: state=%0d, expected %0d", vecs[i].nm, hz.state_o, vecs[i].exp_next);
            end
            reset_pulse();
        end

        // back-to-back load-use: each gets exactly one bubble cycle
        @(negedge CLK); set_ld_use(5'd5); #1; check_cs("b2b_lu1", CB, 3'd0);
        @(negedge CLK); #1;                   check_cs("b2b_hold1", C0, 3'd3);
        @(negedge CLK); set_ld_use(5'd6); #1; check_cs("b2b_lu2", CB, 3'd0);
        @(negedge CLK); #1;                   check_cs("b2b_hold2", C0, 3'd3);
        @(negedge CLK); clear_inputs(); #1;   check_cs("b2b_done", C0, 3'd0);

        // memory wait: 4 not-ready cycles plus the ready cycle stall, released after
        @(negedge CLK); hz.mem_req = 1'b1; #1; check_cs("mw_c0", CM, 3'd0);
        for (int i = 1; i < 4; i++) begin
            @(negedge CLK); #1; check_cs("mw_wait", CM, 3'd1);
        end
        @(negedge CLK); hz.mem_ready = 1'b1; #1; check_cs("mw_ready", CM, 3'd1);
        @(negedge CLK); clear_inputs(); #1;      check_cs("mw_release", C0, 3'd0);

        // redirect pulse flushes for exactly FLUSH_CYCLES cycles
        begin
            int nflush;
            nflush = 0;
            @(negedge CLK); hz.redirect = 1'b1;
            for (int i = 0; i < 6; i++) begin
                #1;
                if (hz.flush_if && hz.flush_id) nflush++;
                @(negedge CLK);
                hz.redirect = 1'b0;
            end
            checks++;
            if (nflush != 2) begin
                failures++;
                $display("FAIL flush_len: got %0d cycles, expected 2", nflush);
            end
        end

        // load-use during FLUSH is ignored
        @(negedge CLK); hz.redirect = 1'b1; #1;                 check_cs("fl_enter", CF, 3'd0);
        @(negedge CLK); hz.redirect = 1'b0; set_ld_use(5'd9); #1; check_cs("fl_ignore_lu", CF, 3'd2);
        @(negedge CLK); clear_inputs(); #1;                     check_cs("fl_exit", C0, 3'd0);

        // second redirect inside FLUSH reloads the counter
        @(negedge CLK); hz.redirect = 1'b1; #1; check_cs("rl_first", CF, 3'd0);
        @(negedge CLK); #1;                     check_cs("rl_again", CF, 3'd2);
        @(negedge CLK); hz.redirect = 1'b0; #1; check_cs("rl_tail", CF, 3'd2);
        @(negedge CLK); #1;                     check_cs("rl_done", C0, 3'd0);

        // JALR base from EX, then from a MEM load, then clear
        @(negedge CLK);
        hz.id_valid = 1'b1; hz.id_opcode = OPC_JALR; hz.id_rs1 = 5'd7; hz.ex_wb = 1'b1; hz.ex_rd = 5'd7;
        #1; check_cs("jw_ex", CB, 3'd0);
        @(negedge CLK); hz.ex_wb = 1'b0; hz.ex_rd = '0; hz.mem_load = 1'b1; hz.mem_rd = 5'd7;
        #1; check_cs("jw_mem", CB, 3'd4);
        @(negedge CLK); hz.mem_load = 1'b0; hz.mem_rd = '0;
        #1; check_cs("jw_clear", C0, 3'd4);
        @(negedge CLK); clear_inputs(); #1; check_cs("jw_run", C0, 3'd0);

        // redirect during MEM_WAIT becomes a full flush after the wait
        @(negedge CLK); hz.mem_req = 1'b1; #1;                      check_cs("pr_c0", CM, 3'd0);
        @(negedge CLK); hz.redirect = 1'b1; #1;                     check_cs("pr_redir", CM, 3'd1);
        @(negedge CLK); hz.redirect = 1'b0; hz.mem_ready = 1'b1; #1; check_cs("pr_ready", CM, 3'd1);
        @(negedge CLK); clear_inputs(); #1;                         check_cs("pr_fl1", CF, 3'd2);
        @(negedge CLK); #1;                                         check_cs("pr_fl2", CF, 3'd2);
        @(negedge CLK); #1;                                         check_cs("pr_done", C0, 3'd0);

        // timeout after 15 MEM_WAIT cycles with mem_ready never asserted
        @(negedge CLK); hz.mem_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge CLK);
            #1;
            if (i == 15) begin
                check_bit("tmo_not_yet", hz.mem_timeout, 1'b0);
                check_cs("tmo_last_wait", CM, 3'd1);
            end
        end
        @(negedge CLK); hz.mem_req = 1'b0; #1;
        check_bit("tmo_set", hz.mem_timeout, 1'b1);
        check_cs("tmo_run", C0, 3'd0);
        @(negedge CLK); #1;
        check_bit("tmo_sticky", hz.mem_timeout, 1'b1);

        // asynchronous reset in the middle of MEM_WAIT
        @(negedge CLK); hz.mem_req = 1'b1;
        repeat (3) @(negedge CLK);
        #1; check_cs("rst_pre", CM, 3'd1);
        reset = 1'b0;
        #1;
        check_cs("rst_async", C0, 3'd0);
        check_bit("rst_tmo_clr", hz.mem_timeout, 1'b0);
        @(negedge CLK); clear_inputs(); reset = 1'b1; #1;
        check_cs("rst_release", C0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
